// File: rtl/freq_counter_bank.sv
// -----------------------------------------------------------------------------
// freq_counter_bank
//
// Multi-channel frequency counter referenced to the OCXO clock. Over back-to-back
// gate windows of gate_len = frequency_clk_ref * gate_scale reference cycles it
// counts rising edges on 5 XO and 10 TCXO inputs. At each window end it
// publishes the reference count, every channel count and every channel's
// absolute deviation from the reference count.
//
// Ports:
//   clk_ocxo          in   reference clock, the only clock in the block
//   rst               in   asynchronous active-low reset
//   EN                in   measurement enable (low: counters held at 0)
//   ixo1..ixo5        in   XO inputs, asynchronous to clk_ocxo
//   itcxo1..itcxo10   in   TCXO inputs, asynchronous to clk_ocxo
//   ocxo_cnt          out  reference cycles in the last completed gate
//   oxo1..oxo5        out  edge counts of ixo1..ixo5 in the last gate
//   otcxo1..otcxo10   out  edge counts of itcxo1..itcxo10 in the last gate
//   error1..error15   out  |ocxo_cnt - count|; 1..5 -> oxo1..5, 6..15 -> otcxo1..10
// -----------------------------------------------------------------------------
module freq_counter_bank #(
  parameter int unsigned bit_cnt           = 25,
  parameter int unsigned frequency_clk_ref = 16,
  parameter int unsigned gate_scale        = 1000000
) (
  input  logic               clk_ocxo,
  input  logic               rst,
  input  logic               EN,
  input  logic               ixo1,
  input  logic               ixo2,
  input  logic               ixo3,
  input  logic               ixo4,
  input  logic               ixo5,
  input  logic               itcxo1,
  input  logic               itcxo2,
  input  logic               itcxo3,
  input  logic               itcxo4,
  input  logic               itcxo5,
  input  logic               itcxo6,
  input  logic               itcxo7,
  input  logic               itcxo8,
  input  logic               itcxo9,
  input  logic               itcxo10,
  output logic [bit_cnt-1:0] ocxo_cnt,
  output logic [bit_cnt-1:0] oxo1,
  output logic [bit_cnt-1:0] oxo2,
  output logic [bit_cnt-1:0] oxo3,
  output logic [bit_cnt-1:0] oxo4,
  output logic [bit_cnt-1:0] oxo5,
  output logic [bit_cnt-1:0] otcxo1,
  output logic [bit_cnt-1:0] otcxo2,
  output logic [bit_cnt-1:0] otcxo3,
  output logic [bit_cnt-1:0] otcxo4,
  output logic [bit_cnt-1:0] otcxo5,
  output logic [bit_cnt-1:0] otcxo6,
  output logic [bit_cnt-1:0] otcxo7,
  output logic [bit_cnt-1:0] otcxo8,
  output logic [bit_cnt-1:0] otcxo9,
  output logic [bit_cnt-1:0] otcxo10,
  output logic [bit_cnt-1:0] error1,
  output logic [bit_cnt-1:0] error2,
  output logic [bit_cnt-1:0] error3,
  output logic [bit_cnt-1:0] error4,
  output logic [bit_cnt-1:0] error5,
  output logic [bit_cnt-1:0] error6,
  output logic [bit_cnt-1:0] error7,
  output logic [bit_cnt-1:0] error8,
  output logic [bit_cnt-1:0] error9,
  output logic [bit_cnt-1:0] error10,
  output logic [bit_cnt-1:0] error11,
  output logic [bit_cnt-1:0] error12,
  output logic [bit_cnt-1:0] error13,
  output logic [bit_cnt-1:0] error14,
  output logic [bit_cnt-1:0] error15
);

  localparam int num_ch = 15;

  localparam logic [bit_cnt-1:0] gate_len  = bit_cnt'(frequency_clk_ref * gate_scale);
  localparam logic [bit_cnt-1:0] gate_last = gate_len - bit_cnt'(1);
  localparam logic [bit_cnt-1:0] cnt_max   = '1;

  // Channel bus: bit 0 = ixo1 ... bit 4 = ixo5, bit 5 = itcxo1 ... bit 14 = itcxo10.
  logic [num_ch-1:0] ch_in;
  assign ch_in = {itcxo10, itcxo9, itcxo8, itcxo7, itcxo6, itcxo5, itcxo4, itcxo3,
                  itcxo2, itcxo1, ixo5, ixo4, ixo3, ixo2, ixo1};

  // Two synchronizer stages plus one history stage per channel.
  logic [num_ch-1:0] sync_meta;
  logic [num_ch-1:0] sync_q;
  logic [num_ch-1:0] sync_prev;
  logic [num_ch-1:0] edge_det;

  assign edge_det = sync_q & ~sync_prev;

  logic [bit_cnt-1:0] gate_cnt;
  logic               gate_end;

  assign gate_end = EN && (gate_cnt == gate_last);

  logic [bit_cnt-1:0] ch_cnt   [num_ch];
  logic [bit_cnt-1:0] ch_next  [num_ch];
  logic [bit_cnt-1:0] err_next [num_ch];
  logic [bit_cnt-1:0] ch_q     [num_ch];
  logic [bit_cnt-1:0] err_q    [num_ch];

  // Count including this cycle's edge (saturating), and its distance from the
  // reference count. At a window end these are exactly the values published,
  // so an edge detected in the last gate cycle lands in the closing window.
  always_comb begin
    for (int i = 0; i < num_ch; i++) begin
      // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
      ch_next[i] = ch_cnt[i];
      if (edge_det[i] && (ch_cnt[i] != cnt_max)) begin
        ch_next[i] = ch_cnt[i] + bit_cnt'(1);
      end
      err_next[i] = (ch_next[i] > gate_len) ? (ch_next[i] - gate_len)
                                             : (gate_len - ch_next[i]);
    end
  end

  // Synchronizers, gate counter and channel counters. EN low holds all of them
  // at 0 so a re-enable starts a clean window with no stale history.
  always_ff @(posedge clk_ocxo or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_meta <= '0;
      sync_q    <= '0;
      sync_prev <= '0;
      gate_cnt  <= '0;
      for (int i = 0; i < num_ch; i++) begin
        ch_cnt[i] <= '0;
      end
    end else if (!EN) begin
      sync_meta <= '0;
      sync_q    <= '0;
      sync_prev <= '0;
      gate_cnt  <= '0;
      for (int i = 0; i < num_ch; i++) begin
        ch_cnt[i] <= '0;
      end
    end else begin
      sync_meta <= ch_in;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
      gate_cnt  <= gate_end ? '0 : (gate_cnt + bit_cnt'(1));
      // Restart at 0 on the boundary; an edge in the following cycle then
      // makes the counter 1, so the next window starts without a gap.
      for (int i = 0; i < num_ch; i++) begin
        ch_cnt[i] <= gate_end ? '0 : ch_next[i];
      end
    end
  end

  // Published results: updated only at a completed window end.
  always_ff @(posedge clk_ocxo or negedge rst) begin
    if (!rst) begin
      ocxo_cnt <= '0;
      // NOTE: these register arrays are flops, not RAM, and must read 0 after reset, so they are reset element by element.
      for (int i = 0; i < num_ch; i++) begin
        ch_q[i]  <= '0;
        err_q[i] <= '0;
      end
    end else if (gate_end) begin
      ocxo_cnt <= gate_len;
      for (int i = 0; i < num_ch; i++) begin
        ch_q[i]  <= ch_next[i];
        err_q[i] <= err_next[i];
      end
    end
  end

  assign oxo1    = ch_q[0];
  assign oxo2    = ch_q[1];
  assign oxo3    = ch_q[2];
  assign oxo4    = ch_q[3];
  assign oxo5    = ch_q[4];
  assign otcxo1  = ch_q[5];
  assign otcxo2  = ch_q[6];
  assign otcxo3  = ch_q[7];
  assign otcxo4  = ch_q[8];
  assign otcxo5  = ch_q[9];
  assign otcxo6  = ch_q[10];
  assign otcxo7  = ch_q[11];
  assign otcxo8  = ch_q[12];
  assign otcxo9  = ch_q[13];
  assign otcxo10 = ch_q[14];

  assign error1  = err_q[0];
  assign error2  = err_q[1];
  assign error3  = err_q[2];
  assign error4  = err_q[3];
  assign error5  = err_q[4];
  assign error6  = err_q[5];
  assign error7  = err_q[6];
  assign error8  = err_q[7];
  assign error9  = err_q[8];
  assign error10 = err_q[9];
  assign error11 = err_q[10];
  assign error12 = err_q[11];
  assign error13 = err_q[12];
  assign error14 = err_q[13];
  assign error15 = err_q[14];

endmodule

// File: tb/tb_freq_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_freq_counter_bank
//
// Bench for freq_counter_bank with a 16-cycle gate (frequency_clk_ref=16,
// gate_scale=1). Inputs are driven on the falling edge; an edge-level model of
// the counter (rising edge sampled on clock k is counted on clock k+2) pushes
// the expected publication of each window onto a queue, and the following
// falling edge pops it and compares it with the DUT outputs. Between window
// ends the outputs are compared with the last publication, so any change
// outside a window end is caught.
// -----------------------------------------------------------------------------
module tb_freq_counter_bank;

  localparam int BW       = 25;
  localparam int NCH      = 15;
  localparam int GATE_LEN = 16;

  typedef logic [511:0] chk_t;

  typedef struct packed {
    logic [BW-1:0]           ocxo;
    logic [NCH-1:0][BW-1:0]  ch;
    logic [NCH-1:0][BW-1:0]  err;
  } rec_t;

  logic           clk_ocxo;
  logic           rst;
  logic           EN;
  logic [NCH-1:0] in_bus;

  logic [BW-1:0] ocxo_cnt;
  logic [BW-1:0] oxo1, oxo2, oxo3, oxo4, oxo5;
  logic [BW-1:0] otcxo1, otcxo2, otcxo3, otcxo4, otcxo5;
  logic [BW-1:0] otcxo6, otcxo7, otcxo8, otcxo9, otcxo10;
  logic [BW-1:0] error1, error2, error3, error4, error5;
  logic [BW-1:0] error6, error7, error8, error9, error10;
  logic [BW-1:0] error11, error12, error13, error14, error15;

  logic [NCH-1:0][BW-1:0] obs_ch;
  logic [NCH-1:0][BW-1:0] obs_err;

  assign obs_ch  = {otcxo10, otcxo9, otcxo8, otcxo7, otcxo6, otcxo5, otcxo4, otcxo3,
                    otcxo2, otcxo1, oxo5, oxo4, oxo3, oxo2, oxo1};
  assign obs_err = {error15, error14, error13, error12, error11, error10, error9, error8,
                    error7, error6, error5, error4, error3, error2, error1};

  freq_counter_bank #(
    .bit_cnt           (BW),
    .frequency_clk_ref (16),
    .gate_scale        (1)
  ) dut (
    .clk_ocxo (clk_ocxo),
    .rst      (rst),
    .EN       (EN),
    .ixo1     (in_bus[0]),
    .ixo2     (in_bus[1]),
    .ixo3     (in_bus[2]),
    .ixo4     (in_bus[3]),
    .ixo5     (in_bus[4]),
    .itcxo1   (in_bus[5]),
    .itcxo2   (in_bus[6]),
    .itcxo3   (in_bus[7]),
    .itcxo4   (in_bus[8]),
    .itcxo5   (in_bus[9]),
    .itcxo6   (in_bus[10]),
    .itcxo7   (in_bus[11]),
    .itcxo8   (in_bus[12]),
    .itcxo9   (in_bus[13]),
    .itcxo10  (in_bus[14]),
    .ocxo_cnt (ocxo_cnt),
    .oxo1     (oxo1),
    .oxo2     (oxo2),
    .oxo3     (oxo3),
    .oxo4     (oxo4),
    .oxo5     (oxo5),
    .otcxo1   (otcxo1),
    .otcxo2   (otcxo2),
    .otcxo3   (otcxo3),
    .otcxo4   (otcxo4),
    .otcxo5   (otcxo5),
    .otcxo6   (otcxo6),
    .otcxo7   (otcxo7),
    .otcxo8   (otcxo8),
    .otcxo9   (otcxo9),
    .otcxo10  (otcxo10),
    .error1   (error1),
    .error2   (error2),
    .error3   (error3),
    .error4   (error4),
    .error5   (error5),
    .error6   (error6),
    .error7   (error7),
    .error8   (error8),
    .error9   (error9),
    .error10  (error10),
    .error11  (error11),
    .error12  (error12),
    .error13  (error13),
    .error14  (error14),
    .error15  (error15)
  );

  initial clk_ocxo = 1'b0;
  always #5 clk_ocxo = ~clk_ocxo;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus control
  int  mode;       // 0 basic, 1 independence, 2 boundary pulse, 3 fast idle toggling
  int  bnd_off;    // boundary pulse offset (0: detected in last gate cycle, 1: one later)
  bit  en_drv;
  bit  rst_req;
  int  cyc = 0;

  // Model state
  logic [NCH-1:0] last_in, pend1, pend2;
  int             win_cnt [NCH];
  int             gate_pos;
  int             win_no;
  rec_t           held;
  rec_t           exp_q [$];

  task automatic model_clear();
    last_in  = '0;
    pend1    = '0;
    pend2    = '0;
    gate_pos = 0;
    win_no   = 0;
    for (int i = 0; i < NCH; i++) win_cnt[i] = 0;
  endtask

  function automatic logic [NCH-1:0] pattern(input int c);
    logic [NCH-1:0] p;
    int idx;
    p   = '0;
    idx = gate_pos + 1;  // index within the window of the clock edge about to sample
    for (int i = 0; i < NCH; i++) begin
      case (mode)
        0: p[i] = (((c + i) / 2) % 2) == 1;
        1: begin
          if (i == 0)       p[i] = ((c / 2) % 2) == 1;
          else if (i == 14) p[i] = 1'b0;
          else              p[i] = (((c + i) / 4) % 2) == 1;
        end
        2: p[i] = (i == 0) && (win_no == 0) &&
                  ((idx == 14 + bnd_off) || (idx == 15 + bnd_off));
        default: p[i] = ((c + i) % 2) == 1;
      endcase
    end
    return p;
  endfunction

  // One clock: compare last edge's results, optionally pulse reset, then drive
  // the next edge's inputs and advance the model over that edge.
  task automatic step();
    rec_t           r;
    logic [NCH-1:0] cur;
    @(negedge clk_ocxo);
    if (exp_q.size() > 0) held = exp_q.pop_front();
    check("ocxo_cnt", chk_t'(ocxo_cnt), chk_t'(held.ocxo));
    check("chan_cnt", chk_t'(obs_ch), chk_t'(held.ch));
    check("chan_err", chk_t'(obs_err), chk_t'(held.err));

    if (rst_req) begin
      #1 rst = 1'b0;
      #1;
      check("rst_async_ocxo", chk_t'(ocxo_cnt), '0);
      check("rst_async_chan", chk_t'(obs_ch), '0);
      check("rst_async_err", chk_t'(obs_err), '0);
      held = '0;
      exp_q.delete();
      model_clear();
      #1 rst = 1'b1;
      rst_req = 1'b0;
    end

    cur    = pattern(cyc);
    in_bus = cur;
    EN     = en_drv;
    if (!en_drv || !rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < NCH; i++) if (pend2[i]) win_cnt[i]++;
      pend2   = pend1;
      pend1   = cur & ~last_in;
      last_in = cur;
      gate_pos++;
      if (gate_pos == GATE_LEN) begin
        r.ocxo = BW'(GATE_LEN);
        for (int i = 0; i < NCH; i++) begin
          r.ch[i]  = BW'(win_cnt[i]);
          r.err[i] = (win_cnt[i] > GATE_LEN) ? BW'(win_cnt[i] - GATE_LEN)
                                             : BW'(GATE_LEN - win_cnt[i]);
          win_cnt[i] = 0;
        end
        exp_q.push_back(r);
        gate_pos = 0;
        win_no++;
      end
    end
    cyc++;
  endtask

  initial begin
    rst     = 1'b0;
    EN      = 1'b0;
    in_bus  = '0;
    mode    = 3;
    bnd_off = 0;
    en_drv  = 1'b0;
    rst_req = 1'b0;
    held    = '0;
    model_clear();

    // Reset held with inputs toggling, then idle with EN low.
    repeat (5) step();
    rst = 1'b1;
    repeat (100) step();

    // Basic window: every channel rises every 4 cycles.
    mode   = 0;
    en_drv = 1'b1;
    repeat (49) step();
    check("basic_ocxo", chk_t'(ocxo_cnt), chk_t'(16));
    check("basic_oxo1", chk_t'(oxo1), chk_t'(4));
    check("basic_otcxo10", chk_t'(otcxo10), chk_t'(4));
    check("basic_error1", chk_t'(error1), chk_t'(12));
    check("basic_error15", chk_t'(error15), chk_t'(12));
    repeat (16) step();

    // Per-channel independence.
    mode = 1;
    repeat (48) step();
    check("indep_oxo1", chk_t'(oxo1), chk_t'(4));
    check("indep_error1", chk_t'(error1), chk_t'(12));
    check("indep_otcxo10", chk_t'(otcxo10), chk_t'(0));
    check("indep_error15", chk_t'(error15), chk_t'(16));
    check("indep_oxo2", chk_t'(oxo2), chk_t'(2));
    check("indep_error2", chk_t'(error2), chk_t'(14));
    check("indep_otcxo1", chk_t'(otcxo1), chk_t'(2));

    // EN drop 8 cycles into a window, then a full window after re-enable.
    repeat (7) step();
    en_drv = 1'b0;
    repeat (5) step();
    en_drv = 1'b1;
    repeat (16) step();
    check("endrop_hold_oxo1", chk_t'(oxo1), chk_t'(4));
    check("endrop_hold_otcxo10", chk_t'(otcxo10), chk_t'(0));
    repeat (17) step();

    // Asynchronous reset pulse mid-window, counting restarts from 0.
    repeat (5) step();
    rst_req = 1'b1;
    repeat (33) step();
    check("post_rst_ocxo", chk_t'(ocxo_cnt), chk_t'(16));
    check("post_rst_oxo1", chk_t'(oxo1), chk_t'(4));

    // Boundary: edge detected in the last gate cycle belongs to the closing window.
    en_drv = 1'b0;
    repeat (3) step();
    mode    = 2;
    bnd_off = 0;
    en_drv  = 1'b1;
    repeat (17) step();
    check("bnd0_win0_oxo1", chk_t'(oxo1), chk_t'(1));
    check("bnd0_win0_error1", chk_t'(error1), chk_t'(15));
    check("bnd0_win0_oxo2", chk_t'(oxo2), chk_t'(0));
    repeat (16) step();
    check("bnd0_win1_oxo1", chk_t'(oxo1), chk_t'(0));
    check("bnd0_win1_error1", chk_t'(error1), chk_t'(16));

    // Boundary: edge detected one cycle later belongs to the next window.
    en_drv = 1'b0;
    repeat (3) step();
    bnd_off = 1;
    en_drv  = 1'b1;
    repeat (17) step();
    check("bnd1_win0_oxo1", chk_t'(oxo1), chk_t'(0));
    repeat (16) step();
    check("bnd1_win1_oxo1", chk_t'(oxo1), chk_t'(1));
    check("bnd1_win1_error1", chk_t'(error1), chk_t'(15));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_counter_bank.md
Name: freq_counter_bank

Overview:
- Multi-channel frequency counter referenced to a single OCXO clock.
- Over repeated fixed gate windows it counts rising edges on 15 oscillator inputs (5 XO, 10 TCXO).
- At the end of each window it publishes the reference count, each channel count, and each channel's absolute deviation from the reference count.
- Sits between the oscillator-under-test inputs and the UART reporting logic.

Parameters:
- bit_cnt, 25, width of every counter and of every count/error output.
- frequency_clk_ref, 16, reference clock frequency in MHz.
- gate_scale, 1000000, reference cycles per MHz unit. Gate length is gate_len = frequency_clk_ref * gate_scale (default 16,000,000 cycles = 1 s). gate_len must be < 2^bit_cnt.

Ports:
- clk_ocxo  in  1  reference clock; the only clock in the block.
- rst  in  1  asynchronous active-low reset.
- EN  in  1  measurement enable.
- ixo1..ixo5  in  1 each  XO inputs, asynchronous to clk_ocxo.
- itcxo1..itcxo10  in  1 each  TCXO inputs, asynchronous to clk_ocxo.
- ocxo_cnt  out  bit_cnt  reference cycles counted in the last completed gate.
- oxo1..oxo5  out  bit_cnt each  edge counts for ixo1..5 in the last gate.
- otcxo1..otcxo10  out  bit_cnt each  edge counts for itcxo1..10 in the last gate.
- error1..error15  out  bit_cnt each  |ocxo_cnt − channel count|. error1..5 map to oxo1..5; error6..15 map to otcxo1..10.

Behaviour:
- Reset (rst=0, asynchronous): clears the gate counter, all channel counters, synchronizers, and every output to 0.
- Channel inputs: each passes through a 2-flop synchronizer plus a previous-sample flop. A rising edge is detected when the synchronized value is 1 and the previous sample is 0.
  - Latency from input edge to counter increment: 3 clk_ocxo cycles.
  - Counts are valid only for input frequencies below clk_ocxo/2.
- EN=0:
  - Gate counter, channel counters and synchronizer history are synchronously held at 0.
  - Outputs hold their last latched values.
- EN=1:
  - Gate counter increments every clk_ocxo cycle from 0 to gate_len−1.
  - Each channel counter increments by 1 on every detected rising edge.
  - Channel counters saturate at 2^bit_cnt−1 (no wrap).
- End of gate (gate counter == gate_len−1 with EN=1), on that clock edge:
  - ocxo_cnt <= gate_len.
  - Each channel output <= its counter value, including any edge detected in that same cycle.
  - Each error output <= absolute difference between gate_len and that channel's latched count, computed unsigned with no wrap.
  - Gate counter and channel counters restart: a channel counter becomes 1 if an edge is detected in the restart cycle, otherwise 0. The next window begins with no gap.
- Edges still in the synchronizer pipeline at a boundary are counted in the following window. No edge is lost or double counted.
- EN falling mid-window: the partial window is discarded and outputs are unchanged. EN rising again starts a fresh window at gate count 0.
- rst asserted mid-window: everything, including outputs, returns to 0 immediately.
- All outputs are registered. They change only at window ends or on reset.

Test Plan:
- Reset: hold rst=0 with inputs toggling → all 31 outputs read 0; release rst with EN=0 for 100 cycles → outputs stay 0.
- Basic window (frequency_clk_ref=16, gate_scale=1, gate_len=16): EN=1, every channel toggles every 2 clk_ocxo cycles (rising edge every 4 cycles) → after each 16-cycle window ocxo_cnt=16, every oxo/otcxo=4, every error=12, stable across consecutive windows.
- Per-channel independence: ixo1 at clk/4, itcxo10 held low, others at clk/8 → oxo1=4 with error1=12; otcxo10=0 with error15=16; others=2 with error=14.
- EN drop: deassert EN 8 cycles into a window, then reassert → outputs keep the previous window's values until a full 16-cycle window completes after reassertion.
- Boundary edge: place a single channel rising edge so its detection lands exactly in cycle gate_len−1 → it is counted in the closing window; an edge detected one cycle later appears in the next window.
- Async reset mid-window: pulse rst low for less than 1 clock period between edges → outputs clear immediately without a clock edge, and counting restarts from 0.
